// File: rtl/uart_pkg.sv
// Shared definitions for the debug UART transmit path: scheduler state
// encoding, default byte/word geometry and an index-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10
    } state_e;

    localparam int UART_N           = 8;
    localparam int DEBUG_WORD_BYTES = 4;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// ptr_i, wrapping modulo NUM_REQ. The pointer itself is owned by the caller.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_req_o
);

    assign any_req_o = |req_i;

    // Rotational distance from the pointer; the closest valid request wins.
    always_comb begin
        int dist_s;
        int best_dist_s;
        grant_o     = '0;
        grant_idx_o = '0;
        dist_s      = 0;
        best_dist_s = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i + NUM_REQ - int'(ptr_i)) % NUM_REQ;
            if (req_i[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                grant_idx_o = IDX_W'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        if (any_req_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ requesters; a granted word is sent
// LSB byte first, one uart_tx frame per byte via tx_start/tx_done.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int N          = UART_N,
    parameter int WORD_BYTES = DEBUG_WORD_BYTES,
    parameter int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*WORD_BYTES*N-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              req_done,
    output logic                            tx_start,
    output logic [N-1:0]                    tx_data,
    input  logic                            tx_done,
    output logic                            busy,
    output logic [IDX_W-1:0]                grant_id
);

    localparam int W     = WORD_BYTES * N;
    localparam int CNT_W = idx_width(WORD_BYTES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [W-1:0]       shift_q, shift_d;
    logic [W-1:0]       word_sel_s;
    logic [NUM_REQ-1:0] grant_oh_s, ready_s, done_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               any_req_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_oh_s),
        .grant_idx_o (grant_idx_s),
        .any_req_o   (any_req_s)
    );

    // Pick the granted requester's word out of the flat data bus.
    always_comb begin
        word_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh_s[i]) begin
                word_sel_s = req_data[i*W +: W];
            end else begin
                word_sel_s = word_sel_s;
            end
        end
    end

    // Next-state and pulse decode; tx_done is only honoured in WAIT.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        ready_s    = '0;
        done_s     = '0;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    ready_s    = grant_oh_s;
                    shift_d    = word_sel_s;
                    grant_id_d = grant_idx_s;
                    byte_cnt_d = '0;
                    rr_ptr_d   = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx_s + IDX_W'(1);
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!tx_done) begin
                    state_d = WAIT;
                end else if (byte_cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                    done_s[grant_id_q] = 1'b1;
                    state_d            = IDLE;
                end else begin
                    shift_d    = shift_q >> N;
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    state_d    = START;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // req_ready is gated so a pending request cannot show through while in reset.
    assign req_ready = ready_s & {NUM_REQ{reset}};
    assign req_done  = done_s;
    assign tx_start  = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign tx_data   = shift_q[N-1:0];
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a byte/grant scoreboard and a
// uart_tx stand-in that answers each tx_start with tx_done five cycles later.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_data;
    logic [1:0]  req_ready, req_done;
    logic        tx_start, tx_done, busy;
    logic [7:0]  tx_data;
    logic [0:0]  grant_id;

    logic        rv1, rr1, rdn1, ts1, tdn1, busy1;
    logic [7:0]  rd1, txd1;
    logic [0:0]  gid1;

    logic model_done = 1'b0;
    logic man_done   = 1'b0;
    int   cd         = 0;
    assign tx_done = model_done | man_done;

    int checks  = 0;
    int errors  = 0;
    int n_starts = 0;

    typedef struct {
        logic [7:0] b;
        logic [0:0] g;
    } exp_t;
    exp_t exp_q[$];
    int   done_q[$];

    uart_tx_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .tx_start(tx_start),
        .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_scheduler #(.NUM_REQ(1), .N(8), .WORD_BYTES(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_data(rd1),
        .req_ready(rr1), .req_done(rdn1), .tx_start(ts1),
        .tx_data(txd1), .tx_done(tdn1), .busy(busy1), .grant_id(gid1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int g, input int nbytes);
        exp_t e;
        for (int i = 0; i < nbytes; i++) begin
            e.b = w[i*8 +: 8];
            e.g = 1'(g);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_for_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_done == 2'b00 && n < 500);
        check(tag, 32'(req_done == 2'b00), 32'(1'b0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    // uart_tx stand-in
    always @(posedge clk) begin
        if (!reset) begin
            cd         <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (tx_start) begin
                cd <= 5;
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) model_done <= 1'b1;
            end
        end
    end

    // Scoreboard: every tx_start pops a byte, every req_done pops a requester.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (reset) begin
            if (tx_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_start", 32'(tx_start), 32'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_tx_data", 32'(tx_data), 32'(e.b));
                    check("sb_grant_id", 32'(grant_id), 32'(e.g));
                end
            end
            if (req_done != 2'b00) begin
                if (done_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(req_done), 32'(2'b00));
                end else begin
                    d = done_q.pop_front();
                    check("sb_req_done", 32'(req_done), 32'(2'b01) << d);
                    check("sb_done_with_tx_done", 32'(tx_done), 32'(1'b1));
                end
            end
        end
    end

    initial begin
        int s0;
        int g;
        int n;
        logic [1:0] ord [3];
        ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01;
        reset = 1'b0; req_valid = 2'b00; req_data = 64'h0;
        rv1 = 1'b0; rd1 = 8'h00; tdn1 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_tx_start", 32'(tx_start), 32'(1'b0));
        check("rst_tx_data", 32'(tx_data), 32'(8'h00));
        check("rst_req_ready", 32'(req_ready), 32'(2'b00));
        check("rst_req_done", 32'(req_done), 32'(2'b00));
        check("rst_grant_id", 32'(grant_id), 32'(1'b0));
        @(posedge clk); #1 reset = 1'b1;

        // Single word
        @(posedge clk); #1;
        req_valid = 2'b01; req_data[31:0] = 32'hA1B2C3D4;
        push_word(32'hA1B2C3D4, 0, 4); done_q.push_back(0);
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'(2'b01));
        s0 = n_starts;
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("t1_start_latency", 32'(tx_start), 32'(1'b1));
        wait_for_done("t1_done_timeout");
        check("t1_busy_at_done", 32'(busy), 32'(1'b1));
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'(1'b0));
        check("t1_nstarts", 32'(n_starts - s0), 32'd4);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Contention from reset
        do_reset();
        req_valid = 2'b11; req_data = {32'h55667788, 32'h11223344};
        push_word(32'h11223344, 0, 4); push_word(32'h55667788, 1, 4);
        done_q.push_back(0); done_q.push_back(1);
        @(negedge clk);
        check("t2_ready0", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1 req_valid = 2'b10;
        wait_for_done("t2_done0_timeout");
        @(negedge clk);
        check("t2_ready1", 32'(req_ready), 32'(2'b10));
        check("t2_gap_no_start", 32'(tx_start), 32'(1'b0));
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("t2_gap_start", 32'(tx_start), 32'(1'b1));
        check("t2_gap_data", 32'(tx_data), 32'(8'h88));
        wait_for_done("t2_done1_timeout");
        @(negedge clk);
        check("t2_idle", 32'(busy), 32'(1'b0));
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Fairness: req0 continuously valid, req1 joins during word 0
        do_reset();
        req_valid = 2'b01; req_data = {32'h1A1B1C1D, 32'h0A0B0C0D};
        push_word(32'h0A0B0C0D, 0, 4); push_word(32'h1A1B1C1D, 1, 4); push_word(32'h0A0B0C0D, 0, 4);
        done_q.push_back(0); done_q.push_back(1); done_q.push_back(0);
        g = 0; n = 0;
        while (!(g == 3 && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
            if (req_ready != 2'b00) begin
                if (g < 3) check("t3_order", 32'(req_ready), 32'(ord[g]));
                else       check("t3_extra_grant", 32'(req_ready), 32'(2'b00));
                g++;
                @(posedge clk); #1;
                if (g == 1)      req_valid = 2'b11;
                else if (g == 2) req_valid = 2'b01;
                else             req_valid = 2'b00;
            end
        end
        check("t3_timeout", 32'(n >= 3000), 32'(1'b0));
        check("t3_sb_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

        // Spurious tx_done in IDLE and in START
        do_reset();
        @(posedge clk); #1 man_done = 1'b1;
        @(negedge clk);
        check("t4_idle_busy", 32'(busy), 32'(1'b0));
        check("t4_idle_start", 32'(tx_start), 32'(1'b0));
        @(posedge clk); #1 man_done = 1'b0;
        @(negedge clk);
        check("t4_idle_after", 32'({busy, tx_start}), 32'(2'b00));
        s0 = n_starts;
        @(posedge clk); #1;
        req_valid = 2'b01; req_data[31:0] = 32'h9988F0E1;
        push_word(32'h9988F0E1, 0, 4); done_q.push_back(0);
        @(negedge clk);
        check("t4_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1 req_valid = 2'b00; man_done = 1'b1;
        @(negedge clk);
        check("t4_start", 32'(tx_start), 32'(1'b1));
        @(posedge clk); #1 man_done = 1'b0;
        @(negedge clk);
        check("t4_wait", 32'({busy, tx_start}), 32'(2'b10));
        wait_for_done("t4_done_timeout");
        @(negedge clk);
        check("t4_nstarts", 32'(n_starts - s0), 32'd4);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Async reset in WAIT after byte 2, then req1 only
        do_reset();
        req_valid = 2'b01; req_data[31:0] = 32'hDEADBEEF;
        push_word(32'hDEADBEEF, 0, 2);
        s0 = n_starts;
        @(negedge clk);
        check("t5_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1 req_valid = 2'b00;
        n = 0;
        while ((n_starts - s0) < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_two_bytes", 32'(n_starts - s0), 32'd2);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0; req_valid = 2'b10; req_data[63:32] = 32'h01020304;
        #1;
        check("t5_rst_busy", 32'(busy), 32'(1'b0));
        check("t5_rst_start", 32'(tx_start), 32'(1'b0));
        check("t5_rst_data", 32'(tx_data), 32'(8'h00));
        check("t5_rst_ready_done", 32'({req_ready, req_done}), 32'(4'b0000));
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        push_word(32'h01020304, 1, 4); done_q.push_back(1);
        @(negedge clk);
        check("t5_regrant", 32'(req_ready), 32'(2'b10));
        @(posedge clk); #1 req_valid = 2'b00;
        wait_for_done("t5_done_timeout");
        @(negedge clk);
        check("t5_idle", 32'(busy), 32'(1'b0));
        check("t5_grant_id", 32'(grant_id), 32'(1'b1));
        check("t5_sb_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

        // NUM_REQ=1, WORD_BYTES=1 instance
        @(posedge clk); #1 rv1 = 1'b1; rd1 = 8'h5A;
        @(negedge clk);
        check("t6_ready", 32'(rr1), 32'(1'b1));
        @(negedge clk);
        check("t6_start", 32'(ts1), 32'(1'b1));
        check("t6_data", 32'(txd1), 32'(8'h5A));
        check("t6_gid", 32'(gid1), 32'(1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1 tdn1 = 1'b1;
        @(negedge clk);
        check("t6_done", 32'(rdn1), 32'(1'b1));
        @(posedge clk); #1 tdn1 = 1'b0;
        @(negedge clk);
        check("t6_regrant_ready", 32'({rr1, ts1}), 32'(2'b10));
        @(posedge clk); #1 rv1 = 1'b0;
        @(negedge clk);
        check("t6_regrant_start", 32'(ts1), 32'(1'b1));
        check("t6_regrant_data", 32'(txd1), 32'(8'h5A));
        @(posedge clk); #1 tdn1 = 1'b1;
        @(negedge clk);
        check("t6_done2", 32'(rdn1), 32'(1'b1));
        @(posedge clk); #1 tdn1 = 1'b0;
        @(negedge clk);
        check("t6_idle", 32'({busy1, rr1}), 32'(2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
